// File: rtl/agc_pkg.sv
// Shared AGC definitions: gain Q-format constants and the loop-control state encoding.
package agc_pkg;

  localparam int AGC_GAIN_FRAC  = 12;
  localparam int AGC_GAIN_UNITY = 1 << AGC_GAIN_FRAC;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMP  = 2'd1,
    ST_UPD  = 2'd2
  } agc_state_e;

endpackage

// File: rtl/agc_gain_mult.sv
// Two-stage sample gain pipeline: signed multiply by an unsigned Q gain, then
// round-half-up, saturate and flag clipping.
module agc_gain_mult
  import agc_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int GAIN_WIDTH = 16,
  parameter int GAIN_FRAC  = AGC_GAIN_FRAC
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic signed [DATA_WIDTH-1:0] i_data,
  input  logic                         i_valid,
  input  logic        [GAIN_WIDTH-1:0] i_gain,
  output logic signed [DATA_WIDTH-1:0] o_data,
  output logic                         o_valid,
  output logic                         o_sat
);

  localparam int PW = DATA_WIDTH + GAIN_WIDTH + 1;
  localparam int RW = PW + 1;

  localparam logic signed [RW-1:0] ROUND_BIAS =
    {{(RW-GAIN_FRAC){1'b0}}, 1'b1, {(GAIN_FRAC-1){1'b0}}};
  localparam logic signed [RW-1:0] SAT_MAX =
    {{(RW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [RW-1:0] SAT_MIN =
    {{(RW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  logic signed [PW-1:0]         prod_reg;
  logic                         v1_reg;
  logic signed [RW-1:0]         rounded;
  logic signed [DATA_WIDTH-1:0] data_next;
  logic                         sat_next;
  logic signed [DATA_WIDTH-1:0] data_reg;
  logic                         valid_reg;
  logic                         sat_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      prod_reg <= '0;
      v1_reg   <= 1'b0;
    end else begin
      v1_reg <= i_valid;
      if (i_valid) begin
        prod_reg <= $signed(i_data) * $signed({1'b0, i_gain});
      end
    end
  end

  // Extra headroom bit keeps the rounding add from wrapping before the shift.
  always_comb begin
    rounded   = ($signed({prod_reg[PW-1], prod_reg}) + ROUND_BIAS) >>> GAIN_FRAC;
    data_next = rounded[DATA_WIDTH-1:0];
    sat_next  = 1'b0;
    if (rounded > SAT_MAX) begin
      data_next = {1'b0, {(DATA_WIDTH-1){1'b1}}};
      sat_next  = 1'b1;
    end else if (rounded < SAT_MIN) begin
      data_next = {1'b1, {(DATA_WIDTH-1){1'b0}}};
      sat_next  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_reg  <= '0;
      valid_reg <= 1'b0;
      sat_reg   <= 1'b0;
    end else begin
      valid_reg <= v1_reg;
      sat_reg   <= v1_reg & sat_next;
      if (v1_reg) begin
        data_reg <= data_next;
      end
    end
  end

  assign o_data  = data_reg;
  assign o_valid = valid_reg;
  assign o_sat   = sat_reg;

endmodule

// File: rtl/agc_gain_ctrl.sv
// Closed-loop AGC: compares window levels with a target, steps a clamped gain
// with hysteresis and lock tracking, and applies the gain to the sample stream.
module agc_gain_ctrl
  import agc_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int GAIN_WIDTH = 16,
  parameter int GAIN_FRAC  = AGC_GAIN_FRAC,
  parameter int GAIN_INIT  = AGC_GAIN_UNITY,
  parameter int GAIN_MIN   = 256,
  parameter int GAIN_MAX   = 32767,
  parameter int STEP_SHIFT = 4,
  parameter int LOCK_COUNT = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic        [DATA_WIDTH-1:0] i_level,
  input  logic                         i_level_valid,
  input  logic        [DATA_WIDTH-1:0] i_target,
  input  logic        [DATA_WIDTH-1:0] i_hyst,
  input  logic                         i_freeze,
  input  logic signed [DATA_WIDTH-1:0] i_data,
  input  logic                         i_valid,
  output logic signed [DATA_WIDTH-1:0] o_data,
  output logic                         o_valid,
  output logic                         o_sat,
  output logic        [GAIN_WIDTH-1:0] o_gain,
  output logic                         o_gain_valid,
  output logic                         o_locked,
  output logic                         o_overrun
);

  localparam int EW  = DATA_WIDTH + 1;
  localparam int SW  = GAIN_WIDTH + 2;
  localparam int LCW = $clog2(LOCK_COUNT + 1);

  localparam logic [LCW-1:0]        LOCK_MAX = LCW'(LOCK_COUNT);
  localparam logic signed [SW-1:0]  GMIN_S   = SW'(GAIN_MIN);
  localparam logic signed [SW-1:0]  GMAX_S   = SW'(GAIN_MAX);

  agc_state_e state_reg, state_next;
  logic latch_en, cmp_en, upd_en, overrun_next;

  logic [DATA_WIDTH-1:0] level_reg, target_reg, hyst_reg;
  logic signed [EW-1:0]  err_reg, err_next, err_abs, shifted, delta;
  logic                  inband_reg, inband_next;
  logic [LCW-1:0]        lock_cnt_reg, lock_cnt_next;
  logic                  locked_reg;
  logic [GAIN_WIDTH-1:0] gain_reg, gain_next;
  logic signed [SW-1:0]  gain_sum;
  logic                  gain_valid_reg, overrun_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (i_level_valid) state_next = ST_CMP;
      ST_CMP:  state_next = ST_UPD;
      ST_UPD:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    latch_en     = 1'b0;
    cmp_en       = 1'b0;
    upd_en       = 1'b0;
    overrun_next = 1'b0;
    case (state_reg)
      ST_IDLE: latch_en = i_level_valid;
      ST_CMP: begin
        cmp_en       = 1'b1;
        overrun_next = i_level_valid;
      end
      ST_UPD: begin
        upd_en       = 1'b1;
        overrun_next = i_level_valid;
      end
      default: overrun_next = i_level_valid;
    endcase
  end

  always_comb begin
    err_next    = $signed({1'b0, target_reg}) - $signed({1'b0, level_reg});
    err_abs     = err_next[EW-1] ? -err_next : err_next;
    inband_next = (err_abs <= $signed({1'b0, hyst_reg}));
    if (!inband_next) begin
      lock_cnt_next = '0;
    end else if (lock_cnt_reg == LOCK_MAX) begin
      lock_cnt_next = lock_cnt_reg;
    end else begin
      lock_cnt_next = lock_cnt_reg + 1'b1;
    end
  end

  // Small errors still nudge the gain by one LSB so the loop cannot stall short of target.
  always_comb begin
    shifted = err_reg >>> STEP_SHIFT;
    delta   = shifted;
    if (shifted == 0 && err_reg != 0) begin
      delta = err_reg[EW-1] ? '1 : EW'(1);
    end
    gain_sum = $signed({2'b00, gain_reg}) + SW'(delta);
    if (gain_sum < GMIN_S) begin
      gain_next = GAIN_WIDTH'(GAIN_MIN);
    end else if (gain_sum > GMAX_S) begin
      gain_next = GAIN_WIDTH'(GAIN_MAX);
    end else begin
      gain_next = gain_sum[GAIN_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      level_reg      <= '0;
      target_reg     <= '0;
      hyst_reg       <= '0;
      err_reg        <= '0;
      inband_reg     <= 1'b0;
      lock_cnt_reg   <= '0;
      locked_reg     <= 1'b0;
      gain_reg       <= GAIN_WIDTH'(GAIN_INIT);
      gain_valid_reg <= 1'b0;
      overrun_reg    <= 1'b0;
    end else begin
      overrun_reg    <= overrun_next;
      gain_valid_reg <= 1'b0;
      if (latch_en) begin
        level_reg  <= i_level;
        target_reg <= i_target;
        hyst_reg   <= i_hyst;
      end
      if (cmp_en) begin
        err_reg    <= err_next;
        inband_reg <= inband_next;
        if (!i_freeze) begin
          lock_cnt_reg <= lock_cnt_next;
          locked_reg   <= (lock_cnt_next == LOCK_MAX);
        end
      end
      if (upd_en && !inband_reg && !i_freeze) begin
        gain_reg       <= gain_next;
        gain_valid_reg <= (gain_next != gain_reg);
      end
    end
  end

  agc_gain_mult #(
    .DATA_WIDTH(DATA_WIDTH),
    .GAIN_WIDTH(GAIN_WIDTH),
    .GAIN_FRAC (GAIN_FRAC)
  ) u_mult (
    .clk    (clk),
    .rst    (rst),
    .i_data (i_data),
    .i_valid(i_valid),
    .i_gain (gain_reg),
    .o_data (o_data),
    .o_valid(o_valid),
    .o_sat  (o_sat)
  );

  assign o_gain       = gain_reg;
  assign o_gain_valid = gain_valid_reg;
  assign o_locked     = locked_reg;
  assign o_overrun    = overrun_reg;

endmodule
